// File: rtl/uart_pkg.sv
// Shared definitions for the transmit UART: setup word layout, frame encodings, FSM states.
package uart_pkg;

  localparam int unsigned SetupWidth   = 30;
  localparam int unsigned CpbWidth     = 24;

  // Bit positions inside the 30-bit setup word
  localparam int unsigned SetupLenHi   = 29;
  localparam int unsigned SetupLenLo   = 28;
  localparam int unsigned SetupStop    = 27;
  localparam int unsigned SetupParEn   = 26;
  localparam int unsigned SetupParFix  = 25;
  localparam int unsigned SetupParType = 24;

  // Anything below this would leave no room for a counted bit period
  localparam logic [CpbWidth-1:0] MinCpb = 24'd2;

  typedef enum logic [1:0] {
    Len8 = 2'b00,
    Len7 = 2'b01,
    Len6 = 2'b10,
    Len5 = 2'b11
  } data_len_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBreak,
    StBreakIdle
  } tx_state_e;

  function automatic data_len_e setup_len(input logic [SetupWidth-1:0] setup);
    return data_len_e'(setup[SetupLenHi:SetupLenLo]);
  endfunction

  // Index of the final data bit for a given data length
  function automatic logic [2:0] last_bit_idx(input data_len_e len);
    logic [2:0] idx;
    unique case (len)
      Len8: idx = 3'd7;
      Len7: idx = 3'd6;
      Len6: idx = 3'd5;
      Len5: idx = 3'd4;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic [CpbWidth-1:0] eff_cpb(input logic [CpbWidth-1:0] cpb);
    return (cpb < MinCpb) ? MinCpb : cpb;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: reloads to CPB-1 and ticks when a bit period has elapsed.
module uart_baud_counter
  import uart_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic                i_enable,
  input  logic [CpbWidth-1:0] i_cpb,
  output logic                o_baud_tick
);

  logic [CpbWidth-1:0] count_q, count_d;

  // Tick on the last clock of each period; a load restarts the period
  always_comb begin
    o_baud_tick = i_enable && !i_load && (count_q == '0);
    count_d     = count_q;
    if (i_load || o_baud_tick) begin
      count_d = i_cpb - 24'd1;
    end else if (i_enable) begin
      count_d = count_q - 24'd1;
    end
  end

  // Counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tx_uart.sv
// Transmit-only UART: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
module tx_uart
  import uart_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [SetupWidth-1:0] i_setup,
  input  logic                  i_break,
  input  logic                  i_wr,
  input  logic [7:0]            i_data,
  output logic                  o_uart_tx,
  output logic                  o_busy
);

  tx_state_e             state_q, state_d;
  logic [SetupWidth-1:0] setup_q, setup_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  baud_load;
  logic                  baud_enable;
  logic                  baud_tick;
  logic [CpbWidth-1:0]   baud_cpb;
  logic                  par_bit;

  assign accept = i_wr && !busy_q && !i_break;

  // The accept cycle loads the new CPB directly; otherwise the latched frame value is used
  always_comb begin
    baud_cpb    = accept ? eff_cpb(i_setup[CpbWidth-1:0]) : eff_cpb(setup_q[CpbWidth-1:0]);
    baud_enable = (state_q != StIdle) && (state_q != StBreak);
    if (setup_q[SetupParFix]) begin
      par_bit = setup_q[SetupParType];
    end else begin
      par_bit = setup_q[SetupParType] ? parity_q : ~parity_q;
    end
  end

  uart_baud_counter u_baud (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (baud_load),
    .i_enable    (baud_enable),
    .i_cpb       (baud_cpb),
    .o_baud_tick (baud_tick)
  );

  // Frame sequencing; tx_d is the level for the bit period that starts next cycle
  always_comb begin
    state_d   = state_q;
    setup_d   = setup_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    baud_load = 1'b0;

    if (i_break) begin
      // Break overrides everything, including a frame in flight
      state_d = StBreak;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d   = StStart;
            setup_d   = i_setup;
            shift_d   = i_data;
            parity_d  = 1'b0;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            baud_load = 1'b1;
          end
        end
        StStart: begin
          if (baud_tick) begin
            state_d   = StData;
            tx_d      = shift_q[0];
            parity_d  = parity_q ^ shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          if (baud_tick) begin
            if (bit_cnt_q == last_bit_idx(setup_len(setup_q))) begin
              if (setup_q[SetupParEn]) begin
                state_d = StParity;
                tx_d    = par_bit;
              end else begin
                state_d = StStop1;
                tx_d    = 1'b1;
              end
            end else begin
              tx_d      = shift_q[0];
              parity_d  = parity_q ^ shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (baud_tick) begin
            state_d = StStop1;
            tx_d    = 1'b1;
          end
        end
        StStop1: begin
          if (baud_tick) begin
            tx_d = 1'b1;
            if (setup_q[SetupStop]) begin
              state_d = StStop2;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        StStop2: begin
          if (baud_tick) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
        StBreak: begin
          // Break released: hold mark for one latched bit period before going idle
          state_d   = StBreakIdle;
          tx_d      = 1'b1;
          busy_d    = 1'b1;
          baud_load = 1'b1;
        end
        StBreakIdle: begin
          if (baud_tick) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset forces the line to mark immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      setup_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      setup_q   <= setup_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_tx_uart.sv
// Self-checking bench for tx_uart: scoreboard of written bytes, line decoded per frame.
module tb_tx_uart;

  logic        i_clk;
  logic        i_reset;
  logic [29:0] i_setup;
  logic        i_break;
  logic        i_wr;
  logic [7:0]  i_data;
  logic        o_uart_tx;
  logic        o_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc;

  typedef struct {
    logic [7:0]  data;
    logic [29:0] setup;
  } exp_t;

  exp_t sb[$];

  tx_uart dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_setup   (i_setup),
    .i_break   (i_break),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .o_uart_tx (o_uart_tx),
    .o_busy    (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic int nbits_of(input logic [29:0] s);
    case (s[29:28])
      2'b00:   return 8;
      2'b01:   return 7;
      2'b10:   return 6;
      default: return 5;
    endcase
  endfunction

  function automatic int cpb_of(input logic [29:0] s);
    if (s[23:0] < 24'd2) return 2;
    return int'(s[23:0]);
  endfunction

  function automatic logic par_of(input logic [7:0] d, input logic [29:0] s);
    logic x;
    x = 1'b0;
    for (int i = 0; i < nbits_of(s); i++) x = x ^ d[i];
    if (s[25]) return s[24];
    return s[24] ? x : ~x;
  endfunction

  // Drive one write, wait for acceptance, record the expected frame
  task automatic send_one(input logic [7:0] data, input logic [29:0] setup, input bit push);
    int w;
    exp_t e;
    @(negedge i_clk);
    i_setup = setup;
    i_data  = data;
    i_wr    = 1'b1;
    w = 0;
    while (o_busy !== 1'b0 && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    if (push) begin
      e.data  = data;
      e.setup = setup;
      sb.push_back(e);
    end
    @(posedge i_clk);
    #1;
    accept_cyc = cyc;
    i_wr   = 1'b0;
    i_data = ~data;
  endtask

  // Wait for a start bit, pop the expected frame and check every clock of it
  task automatic check_frame(input string name, output int start_cyc);
    exp_t e;
    logic exp_bits[12];
    logic [7:0] dec;
    logic [7:0] mask;
    int nb, cpb, total, bad, w;
    start_cyc = -1;
    w = 0;
    @(negedge i_clk);
    while (o_uart_tx !== 1'b0 && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    n_assert++;
    if (o_uart_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_timeout: line=%b required=0", name, o_uart_tx);
      return;
    end
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_frame: queue size=0 required>0", name);
      return;
    end
    e = sb.pop_front();
    start_cyc = cyc;
    nb  = nbits_of(e.setup);
    cpb = cpb_of(e.setup);
    total = 0;
    exp_bits[total] = 1'b0;
    total++;
    for (int i = 0; i < nb; i++) begin
      exp_bits[total] = e.data[i];
      total++;
    end
    if (e.setup[26]) begin
      exp_bits[total] = par_of(e.data, e.setup);
      total++;
    end
    exp_bits[total] = 1'b1;
    total++;
    if (e.setup[27]) begin
      exp_bits[total] = 1'b1;
      total++;
    end
    bad = 0;
    dec = 8'h00;
    for (int b = 0; b < total; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge i_clk);
        if (o_uart_tx !== exp_bits[b]) bad++;
        if (o_busy !== 1'b1) bad++;
        if (c == cpb / 2 && b >= 1 && b <= nb) dec[b-1] = o_uart_tx;
      end
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s bit_timing: bad_samples=%0d required=0", name, bad);
    end
    mask = 8'hFF >> (8 - nb);
    n_assert++;
    if (dec !== (e.data & mask)) begin
      n_fail++;
      $display("FAIL %s decode: got=%h required=%h", name, dec, e.data & mask);
    end
    @(negedge i_clk);
    n_assert++;
    if (o_busy !== 1'b0 || o_uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_of_frame: busy=%b line=%b required busy=0 line=1 after %0d clocks",
               name, o_busy, o_uart_tx, total * cpb);
    end
  endtask

  task automatic test_reset();
    int bad;
    n_assert++;
    if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: line=%b busy=%b required line=1 busy=0", o_uart_tx, o_busy);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_line: bad_samples=%0d required=0", bad);
    end
  endtask

  task automatic test_basic();
    int s;
    send_one(8'h48, 30'h0000010, 1'b1);
    check_frame("basic_8N1", s);
    n_assert++;
    if (s != accept_cyc) begin
      n_fail++;
      $display("FAIL basic_latency: start_cycle=%0d required=%0d", s, accept_cyc);
    end
  endtask

  task automatic test_back_to_back();
    string msg;
    int starts[16];
    msg = "Hello, World! \r\n";
    fork
      begin
        exp_t e;
        int w;
        @(negedge i_clk);
        i_setup = 30'h0000010;
        i_wr    = 1'b1;
        for (int k = 0; k < 16; k++) begin
          i_data = msg[k];
          w = 0;
          while (o_busy !== 1'b0 && w < 5000) begin
            @(negedge i_clk);
            w++;
          end
          e.data  = msg[k];
          e.setup = i_setup;
          sb.push_back(e);
          @(posedge i_clk);
          #1;
          if (k < 15) @(negedge i_clk);
        end
        i_wr = 1'b0;
      end
      begin
        for (int k = 0; k < 16; k++) check_frame("b2b", starts[k]);
      end
    join
    for (int k = 1; k < 16; k++) begin
      n_assert++;
      if (starts[k] - starts[k-1] != 161) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got=%0d required=161", k, starts[k] - starts[k-1]);
      end
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_queue_drain: left=%0d required=0", sb.size());
    end
  endtask

  task automatic test_formats();
    int s;
    send_one(8'h41, {6'b011101, 24'd4}, 1'b1);
    check_frame("7E2", s);
    send_one(8'h41, {6'b011100, 24'd4}, 1'b1);
    check_frame("7O2", s);
    send_one(8'h41, {6'b011111, 24'd4}, 1'b1);
    check_frame("7F1_2", s);
    send_one(8'hFF, {6'b110000, 24'd4}, 1'b1);
    check_frame("5N1", s);
    send_one(8'hC3, {6'b000000, 24'd0}, 1'b1);
    check_frame("cpb0", s);
    send_one(8'h5A, {6'b100100, 24'd1}, 1'b1);
    check_frame("6O1_cpb1", s);
  endtask

  task automatic test_refused_write();
    int s;
    int bad;
    send_one(8'h48, 30'h0000010, 1'b1);
    fork
      check_frame("refused_main", s);
      begin
        repeat (20) @(negedge i_clk);
        i_data = 8'h00;
        i_wr   = 1'b1;
        @(negedge i_clk);
        i_wr    = 1'b0;
        i_setup = {6'b000000, 24'd8};
      end
    join
    bad = 0;
    repeat (200) begin
      @(negedge i_clk);
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL refused_not_sent: bad_samples=%0d required=0", bad);
    end
  endtask

  task automatic test_break();
    int n;
    int bad;
    send_one(8'h55, 30'h0000010, 1'b0);
    repeat (30) @(negedge i_clk);
    i_break = 1'b1;
    @(negedge i_clk);
    n_assert++;
    if (o_uart_tx !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_enter: line=%b busy=%b required line=0 busy=1", o_uart_tx, o_busy);
    end
    bad = 0;
    repeat (200) begin
      @(negedge i_clk);
      if (o_uart_tx !== 1'b0 || o_busy !== 1'b1) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL break_hold: bad_samples=%0d required=0", bad);
    end
    i_break = 1'b0;
    @(negedge i_clk);
    n = 0;
    bad = 0;
    while (o_busy === 1'b1 && n < 500) begin
      if (o_uart_tx !== 1'b1) bad++;
      n++;
      @(negedge i_clk);
    end
    n_assert++;
    if (n != 16 || bad != 0) begin
      n_fail++;
      $display("FAIL break_release: mark_clocks=%0d low_samples=%0d required 16 and 0", n, bad);
    end
    n_assert++;
    if (o_uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL break_idle: line=%b required=1", o_uart_tx);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    send_one(8'h00, 30'h0000010, 1'b0);
    repeat (25) @(negedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    n_assert++;
    if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: line=%b busy=%b required line=1 busy=0", o_uart_tx, o_busy);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    send_one(8'hA5, {6'b000000, 24'd3}, 1'b1);
    check_frame("after_reset", s);
  endtask

  initial begin
    i_reset = 1'b1;
    i_setup = 30'h0000010;
    i_break = 1'b0;
    i_wr    = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_formats();
    test_refused_write();
    test_break();
    test_reset_mid_frame();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: left=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
